// File: rtl/handshake_tx_pkg.sv
// Shared constants and FSM state encoding for the handshake_tx four-phase sender.
package handshake_tx_pkg;

    localparam int unsigned DATA_W_DEF  = 4;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/handshake_tx_if.sv
// Producer push strobe, peripheral send/ack pair and status flags of handshake_tx.
interface handshake_tx_if
    import handshake_tx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              tx_wr_valid;
    logic [DATA_W-1:0] tx_wr_data;
    logic              tx_wr_ready;
    logic              tx_send;
    logic [DATA_W-1:0] tx_dados;
    logic              tx_ack;
    logic [CNT_W-1:0]  tx_count;
    logic              tx_busy;
    logic              tx_timeout;

    // master is the transmitter itself; slave is the producer/peripheral side
    modport master (
        input  tx_wr_valid, tx_wr_data, tx_ack,
        output tx_wr_ready, tx_send, tx_dados, tx_count, tx_busy, tx_timeout
    );

    modport slave (
        output tx_wr_valid, tx_wr_data, tx_ack,
        input  tx_wr_ready, tx_send, tx_dados, tx_count, tx_busy, tx_timeout
    );

endinterface

// File: rtl/handshake_tx_fifo.sv
// Circular word buffer for handshake_tx: power-of-two depth, head exposed combinationally.
module handshake_tx_fifo
    import handshake_tx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointers wrap for free because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/handshake_tx.sv
// Buffered four-phase send/ack transmitter; define HANDSHAKE_TX_TIMEOUT_EN to abort a send
// that sees no ack within TIMEOUT cycles.
module handshake_tx
    import handshake_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic           tx_clock,
    input  logic           tx_reset,
    handshake_tx_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    tx_state_t         state, state_nxt;
    logic              send_q, send_nxt;
    logic [DATA_W-1:0] dados_q, dados_nxt;
    logic              timeout_nxt;
    logic              push, pop, start, expire;
    logic              full, empty;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  count;

    handshake_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (tx_clock),
        .rst     (tx_reset),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.tx_wr_data),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Ready follows the registered count, so a pop never makes room in the same cycle
    assign push  = bus.tx_wr_valid && !full;
    assign start = (state == IDLE) && !empty && !bus.tx_ack;

`ifdef HANDSHAKE_TX_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;

    // Held at zero outside SEND, so it starts from zero on every entry
    always_ff @(posedge tx_clock) begin
        if (tx_reset || state != SEND) wait_cnt <= '0;
        else                           wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    assign expire = (state == SEND) && !bus.tx_ack && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge tx_clock) begin
        if (tx_reset) timeout_q <= 1'b0;
        else          timeout_q <= timeout_nxt;
    end

    assign bus.tx_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT);
    assign expire             = 1'b0;
    assign bus.tx_timeout     = 1'b0;
`endif

    always_ff @(posedge tx_clock) begin
        if (tx_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEND;
            SEND:    if (bus.tx_ack || expire) state_nxt = RELEASE;
            RELEASE: if (!bus.tx_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ack wins over an expiring wait counter in the same cycle
    always_comb begin
        send_nxt    = send_q;
        dados_nxt   = dados_q;
        pop         = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    send_nxt  = 1'b1;
                    dados_nxt = head;
                    pop       = 1'b1;
                end
            end
            SEND: begin
                if (bus.tx_ack) begin
                    send_nxt = 1'b0;
                end else if (expire) begin
                    send_nxt    = 1'b0;
                    timeout_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge tx_clock) begin
        if (tx_reset) begin
            send_q  <= 1'b0;
            dados_q <= '0;
        end else begin
            send_q  <= send_nxt;
            dados_q <= dados_nxt;
        end
    end

    assign bus.tx_send     = send_q;
    assign bus.tx_dados    = dados_q;
    assign bus.tx_count    = count;
    assign bus.tx_wr_ready = !full;
    assign bus.tx_busy     = (state != IDLE);

endmodule

// File: tb/tb_handshake_tx.sv
// Directed bench for handshake_tx (DATA_W=4, DEPTH=4, TIMEOUT=15); timeout checks only
// under HANDSHAKE_TX_TIMEOUT_EN.
module tb_handshake_tx;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    handshake_tx_if #(.DATA_W(4), .DEPTH(4)) bus ();

    handshake_tx #(.DATA_W(4), .DEPTH(4), .TIMEOUT(15)) dut (
        .tx_clock (clk),
        .tx_reset (rst),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] d);
        bus.tx_wr_valid = 1'b1;
        bus.tx_wr_data  = d;
        step();
        bus.tx_wr_valid = 1'b0;
    endtask

    // Peripheral: wait for send, check word, ack one cycle, release
    task automatic take_word(input string tag, input logic [3:0] exp);
        int n = 0;
        while (!bus.tx_send && n < 50) begin
            step();
            n++;
        end
        check({tag, "_send"}, 32'(bus.tx_send), 32'd1);
        check({tag, "_dados"}, 32'(bus.tx_dados), 32'(exp));
        bus.tx_ack = 1'b1;
        step();
        check({tag, "_drop"}, 32'(bus.tx_send), 32'd0);
        bus.tx_ack = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.tx_wr_valid = 1'b0;
        bus.tx_wr_data  = 4'h0;
        bus.tx_ack      = 1'b0;
        step();
        step();
        check("rst_send",  32'(bus.tx_send),     32'd0);
        check("rst_dados", 32'(bus.tx_dados),    32'd0);
        check("rst_count", 32'(bus.tx_count),    32'd0);
        check("rst_ready", 32'(bus.tx_wr_ready), 32'd1);
        check("rst_busy",  32'(bus.tx_busy),     32'd0);
        check("rst_tmo",   32'(bus.tx_timeout),  32'd0);
        rst = 1'b0;

        // Single word, one-cycle peripheral
        push_word(4'h3);
        check("t1_count1", 32'(bus.tx_count), 32'd1);
        check("t1_nosend", 32'(bus.tx_send),  32'd0);
        step();
        check("t1_send",   32'(bus.tx_send),  32'd1);
        check("t1_dados",  32'(bus.tx_dados), 32'h3);
        check("t1_count0", 32'(bus.tx_count), 32'd0);
        check("t1_busy",   32'(bus.tx_busy),  32'd1);
        bus.tx_ack = 1'b1;
        step();
        check("t1_sendlo", 32'(bus.tx_send),  32'd0);
        check("t1_hold",   32'(bus.tx_dados), 32'h3);
        check("t1_rel",    32'(bus.tx_busy),  32'd1);
        bus.tx_ack = 1'b0;
        step();
        check("t1_idle",   32'(bus.tx_busy),  32'd0);

        // Fill to full while blocked, then offer 9 against a full FIFO
        bus.tx_ack = 1'b1;
        bus.tx_wr_valid = 1'b1;
        bus.tx_wr_data = 4'h5; step();
        bus.tx_wr_data = 4'h6; step();
        bus.tx_wr_data = 4'h7; step();
        bus.tx_wr_data = 4'h8; step();
        check("t2_full",   32'(bus.tx_count),    32'd4);
        check("t2_nrdy",   32'(bus.tx_wr_ready), 32'd0);
        bus.tx_wr_data = 4'h9; step();
        check("t2_rej",    32'(bus.tx_count),    32'd4);
        check("t2_nosend", 32'(bus.tx_send),     32'd0);
        bus.tx_ack = 1'b0;
        step();
        check("t2_pop",    32'(bus.tx_count),    32'd3);
        check("t2_rdy",    32'(bus.tx_wr_ready), 32'd1);
        check("t2_d5",     32'(bus.tx_dados),    32'h5);
        step();
        check("t2_push9",  32'(bus.tx_count),    32'd4);
        bus.tx_wr_valid = 1'b0;
        take_word("t2_w5", 4'h5);
        take_word("t2_w6", 4'h6);
        take_word("t2_w7", 4'h7);
        take_word("t2_w8", 4'h8);
        take_word("t2_w9", 4'h9);
        check("t2_empty",  32'(bus.tx_count),    32'd0);

        // Simultaneous push/pop at count 2, with pointer wrap
        bus.tx_ack = 1'b1;
        bus.tx_wr_valid = 1'b1;
        bus.tx_wr_data = 4'hA; step();
        bus.tx_wr_data = 4'hB; step();
        check("t3_count2", 32'(bus.tx_count), 32'd2);
        bus.tx_ack = 1'b0;
        bus.tx_wr_data = 4'hC; step();
        bus.tx_wr_valid = 1'b0;
        check("t3_same",   32'(bus.tx_count), 32'd2);
        check("t3_dA",     32'(bus.tx_dados), 32'hA);
        take_word("t3_wA", 4'hA);
        take_word("t3_wB", 4'hB);
        take_word("t3_wC", 4'hC);

        // Ack stuck high across reset release
        rst = 1'b1;
        bus.tx_ack = 1'b1;
        step();
        step();
        rst = 1'b0;
        push_word(4'hD);
        step();
        step();
        check("t4_hold",   32'(bus.tx_send),  32'd0);
        check("t4_count",  32'(bus.tx_count), 32'd1);
        bus.tx_ack = 1'b0;
        step();
        check("t4_send",   32'(bus.tx_send),  32'd1);
        take_word("t4_wD", 4'hD);

        // Reset mid-transaction with 3 words queued
        bus.tx_ack = 1'b1;
        bus.tx_wr_valid = 1'b1;
        bus.tx_wr_data = 4'h1; step();
        bus.tx_wr_data = 4'h2; step();
        bus.tx_wr_data = 4'h3; step();
        bus.tx_wr_data = 4'h4; step();
        bus.tx_wr_valid = 1'b0;
        bus.tx_ack = 1'b0;
        step();
        check("t5_send",   32'(bus.tx_send),  32'd1);
        check("t5_count3", 32'(bus.tx_count), 32'd3);
        rst = 1'b1;
        step();
        check("t5_rsend",  32'(bus.tx_send),     32'd0);
        check("t5_rcount", 32'(bus.tx_count),    32'd0);
        check("t5_rdados", 32'(bus.tx_dados),    32'd0);
        check("t5_ridle",  32'(bus.tx_busy),     32'd0);
        check("t5_rrdy",   32'(bus.tx_wr_ready), 32'd1);
        rst = 1'b0;
        push_word(4'hE);
        take_word("t5_wE", 4'hE);
        check("t5_empty",  32'(bus.tx_count),    32'd0);

`ifdef HANDSHAKE_TX_TIMEOUT_EN
        // Ack never arrives for 6: abort after 15 SEND cycles, then 7 goes out
        bus.tx_ack = 1'b1;
        push_word(4'h6);
        push_word(4'h7);
        bus.tx_ack = 1'b0;
        step();
        check("t6_send6",  32'(bus.tx_send),    32'd1);
        repeat (14) step();
        check("t6_wait",   32'(bus.tx_send),    32'd1);
        check("t6_notmo",  32'(bus.tx_timeout), 32'd0);
        step();
        check("t6_abort",  32'(bus.tx_send),    32'd0);
        check("t6_tmo",    32'(bus.tx_timeout), 32'd1);
        check("t6_rel",    32'(bus.tx_busy),    32'd1);
        step();
        check("t6_pulse",  32'(bus.tx_timeout), 32'd0);
        check("t6_idle",   32'(bus.tx_busy),    32'd0);
        step();
        check("t6_send7",  32'(bus.tx_send),    32'd1);
        check("t6_d7",     32'(bus.tx_dados),   32'h7);
        repeat (14) step();
        bus.tx_ack = 1'b1;
        step();
        check("t6_late_send", 32'(bus.tx_send),    32'd0);
        check("t6_late_tmo",  32'(bus.tx_timeout), 32'd0);
        bus.tx_ack = 1'b0;
        step();
        check("t6_done",   32'(bus.tx_busy),    32'd0);
        check("t6_count",  32'(bus.tx_count),   32'd0);
`else
        // Without the timeout a stalled send waits indefinitely
        push_word(4'hF);
        step();
        repeat (20) step();
        check("t6_wait",   32'(bus.tx_send),    32'd1);
        check("t6_notmo",  32'(bus.tx_timeout), 32'd0);
        check("t6_busy",   32'(bus.tx_busy),    32'd1);
        check("t6_dF",     32'(bus.tx_dados),   32'hF);
        take_word("t6_wF", 4'hF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
